// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the multiplier result path.
//   FP32_W              : width of an FP32 word
//   FLAG_EXC/OVF/UNF    : bit positions inside a 3-bit {exception, overflow, underflow} vector
//   fp32_result_t       : one queued multiplier result, product word plus its three flags
package fp32_pkg;

    localparam int FP32_W   = 32;

    localparam int FLAG_EXC = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

    typedef struct packed {
        logic [FP32_W-1:0] res;
        logic              exc;
        logic              ovf;
        logic              unf;
    } fp32_result_t;

endpackage

// File: rtl/fp32_mul_result_queue_if.sv
// Handshake bundle between the FP32 multiplier, the result queue and its consumer.
//   in_valid/in_ready    : producer handshake, in_ready means the queue is not full
//   in_res               : FP32 product word
//   in_exception/overflow/underflow : multiplier flags for that word
//   out_valid/out_ready  : consumer handshake, out_valid means the queue is not empty
//   out_res/out_flags    : head entry, flags ordered {exception, overflow, underflow}
// The queue uses the slave modport; the producer/consumer side uses master.
interface fp32_mul_result_queue_if;
    import fp32_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FP32_W-1:0] in_res;
    logic              in_exception;
    logic              in_overflow;
    logic              in_underflow;

    logic              out_valid;
    logic              out_ready;
    logic [FP32_W-1:0] out_res;
    logic [2:0]        out_flags;

    modport slave (
        input  in_valid, in_res, in_exception, in_overflow, in_underflow, out_ready,
        output in_ready, out_valid, out_res, out_flags
    );

    modport master (
        output in_valid, in_res, in_exception, in_overflow, in_underflow, out_ready,
        input  in_ready, out_valid, out_res, out_flags
    );

endinterface

// File: rtl/fp32_sat_counter.sv
// Saturating event counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear
//   inc        : count one event; when raised together with clr the result is 1
//   count      : current value, sticks at all-ones instead of wrapping
module fp32_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            // Clear takes effect first, then the event of the same cycle is counted.
            r_count <= inc ? W'(1) : '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/fp32_mul_result_queue.sv
// Result FIFO behind the combinational FP32 multiplier, with sticky flags and
// saturating per-flag event counters.
//   clk, rst_n    : clock and asynchronous active-low reset
//   q             : handshake bundle (slave side), see fp32_mul_result_queue_if
//   level         : current occupancy, 0..DEPTH
//   sticky_flags  : OR of {exc, ovf, unf} of all accepted entries since last clear
//   clear_stat    : one-cycle pulse clearing sticky_flags and the counters
//   exc/ovf/unf_count : number of accepted entries carrying each flag
module fp32_mul_result_queue
    import fp32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fp32_mul_result_queue_if.slave   q,
    output logic [$clog2(DEPTH):0]   level,
    output logic [2:0]               sticky_flags,
    input  logic                     clear_stat,
    output logic [CNT_W-1:0]         exc_count,
    output logic [CNT_W-1:0]         ovf_count,
    output logic [CNT_W-1:0]         unf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    fp32_result_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [2:0]         r_sticky;

    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_in_flags;
    fp32_result_t       w_in_entry;
    fp32_result_t       w_head;

    // Ready is a function of occupancy only, so no combinational path from out_ready.
    assign q.in_ready  = (r_level != LVL_W'(DEPTH));
    assign q.out_valid = (r_level != '0);

    assign w_push = q.in_valid  & q.in_ready;
    assign w_pop  = q.out_valid & q.out_ready;

    always_comb begin
        w_in_flags           = '0;
        w_in_flags[FLAG_EXC] = q.in_exception;
        w_in_flags[FLAG_OVF] = q.in_overflow;
        w_in_flags[FLAG_UNF] = q.in_underflow;
    end

    assign w_in_entry = '{res: q.in_res, exc: q.in_exception,
                          ovf: q.in_overflow, unf: q.in_underflow};

    // Storage is reset as well so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level disambiguates full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Clear first, then OR in the accepted entry's flags: a same-cycle event survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (clear_stat ? 3'b000 : r_sticky) | (w_push ? w_in_flags : 3'b000);
        end
    end

    fp32_sat_counter #(.W(CNT_W)) u_exc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_stat),
        .inc   (w_push & w_in_flags[FLAG_EXC]),
        .count (exc_count)
    );

    fp32_sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_stat),
        .inc   (w_push & w_in_flags[FLAG_OVF]),
        .count (ovf_count)
    );

    fp32_sat_counter #(.W(CNT_W)) u_unf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_stat),
        .inc   (w_push & w_in_flags[FLAG_UNF]),
        .count (unf_count)
    );

    assign w_head       = r_mem[r_rd_ptr];
    assign q.out_res    = w_head.res;
    assign q.out_flags  = {w_head.exc, w_head.ovf, w_head.unf};
    assign level        = r_level;
    assign sticky_flags = r_sticky;

endmodule

// File: tb/tb_fp32_mul_result_queue.sv
module tb_fp32_mul_result_queue;
    import fp32_pkg::*;

    logic clk;
    logic rst_n;
    logic clear_stat;
    logic s_clear_stat;

    logic [2:0]  level;
    logic [2:0]  sticky_flags;
    logic [15:0] exc_count, ovf_count, unf_count;

    logic [1:0]  s_level;
    logic [2:0]  s_sticky;
    logic [1:0]  s_exc, s_ovf, s_unf;

    int tests;
    int errors;

    fp32_result_t sb [$];

    fp32_mul_result_queue_if bus ();
    fp32_mul_result_queue_if sbus ();

    fp32_mul_result_queue #(.DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .q            (bus),
        .level        (level),
        .sticky_flags (sticky_flags),
        .clear_stat   (clear_stat),
        .exc_count    (exc_count),
        .ovf_count    (ovf_count),
        .unf_count    (unf_count)
    );

    // Narrow-counter instance used for saturation.
    fp32_mul_result_queue #(.DEPTH(2), .CNT_W(2)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .q            (sbus),
        .level        (s_level),
        .sticky_flags (s_sticky),
        .clear_stat   (s_clear_stat),
        .exc_count    (s_exc),
        .ovf_count    (s_ovf),
        .unf_count    (s_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: sampled on the falling edge, acts on what the next rising edge does.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got res=%h flags=%b, required no entry", bus.out_res, bus.out_flags);
                end else begin
                    fp32_result_t e;
                    e = sb.pop_front();
                    if (bus.out_res !== e.res || bus.out_flags !== {e.exc, e.ovf, e.unf}) begin
                        errors++;
                        $display("FAIL pop_order: got res=%h flags=%b, required res=%h flags=%b",
                                 bus.out_res, bus.out_flags, e.res, {e.exc, e.ovf, e.unf});
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{res: bus.in_res, exc: bus.in_exception,
                               ovf: bus.in_overflow, unf: bus.in_underflow});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] r, input logic [2:0] f);
        bus.in_valid     = v;
        bus.in_res       = r;
        bus.in_exception = f[2];
        bus.in_overflow  = f[1];
        bus.in_underflow = f[0];
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        while (level != 0 && n < 16) begin
            step();
            n++;
        end
        bus.out_ready = 1'b0;
        tests++;
        if (level !== 3'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got level=%0d model=%0d, required 0", level, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b1, 32'hDEADBEEF, 3'b111);
        step();
        step();
        tests++;
        if (level !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got level=%0d ov=%b ir=%b, required 0 0 1", level, bus.out_valid, bus.in_ready);
        end
        tests++;
        if (bus.out_res !== 32'h0 || bus.out_flags !== 3'b000 || sticky_flags !== 3'b000) begin
            errors++;
            $display("FAIL reset_data: got res=%h flags=%b sticky=%b, required 0", bus.out_res, bus.out_flags, sticky_flags);
        end
        tests++;
        if (exc_count !== 16'd0 || ovf_count !== 16'd0 || unf_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: got %0d %0d %0d, required 0 0 0", exc_count, ovf_count, unf_count);
        end
        set_in(1'b0, 32'h0, 3'b000);
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        set_in(1'b1, 32'h453210E9, 3'b000);
        step();
        set_in(1'b0, 32'h0, 3'b000);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_res !== 32'h453210E9 || bus.out_flags !== 3'b000) begin
            errors++;
            $display("FAIL single_head: got ov=%b res=%h flags=%b, required 1 453210e9 000",
                     bus.out_valid, bus.out_res, bus.out_flags);
        end
        tests++;
        if (level !== 3'd1 || sticky_flags !== 3'b000) begin
            errors++;
            $display("FAIL single_level: got level=%0d sticky=%b, required 1 000", level, sticky_flags);
        end
        drain();
    endtask

    task automatic test_full();
        logic [31:0] words [5];
        words[0] = 32'hC2355062;
        words[1] = 32'h441E5375;
        words[2] = 32'h4B800000;
        words[3] = 32'h361FFFE7;
        words[4] = 32'h3F800000;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, words[i], 3'b000);
            step();
        end
        set_in(1'b1, words[4], 3'b000);
        tests++;
        if (level !== 3'd4 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got level=%0d ir=%b, required 4 0", level, bus.in_ready);
        end
        step();
        tests++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL full_hold: got level=%0d, required 4", level);
        end
        bus.out_ready = 1'b1;
        step();
        tests++;
        if (level !== 3'd3 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_refuse: got level=%0d ir=%b, required 3 1", level, bus.in_ready);
        end
        step();
        tests++;
        if (level !== 3'd3 || int'(level) != sb.size()) begin
            errors++;
            $display("FAIL full_fifth_accept: got level=%0d model=%0d, required 3", level, sb.size());
        end
        drain();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, $urandom, 3'b000);
            step();
            tests++;
            if (level !== 3'd1) begin
                errors++;
                $display("FAIL stream_level: cycle %0d got level=%0d, required 1", i, level);
            end
        end
        drain();
    endtask

    task automatic test_flags();
        clear_stat = 1'b1;
        step();
        clear_stat = 1'b0;
        set_in(1'b1, 32'h00000000, 3'b110);
        step();
        set_in(1'b0, 32'h0, 3'b000);
        tests++;
        if (sticky_flags !== 3'b110 || exc_count !== 16'd1 || ovf_count !== 16'd1 || unf_count !== 16'd0) begin
            errors++;
            $display("FAIL flags_infinf: got sticky=%b exc=%0d ovf=%0d unf=%0d, required 110 1 1 0",
                     sticky_flags, exc_count, ovf_count, unf_count);
        end
        drain();
        tests++;
        if (sticky_flags !== 3'b110 || exc_count !== 16'd1) begin
            errors++;
            $display("FAIL flags_after_pop: got sticky=%b exc=%0d, required 110 1", sticky_flags, exc_count);
        end
    endtask

    task automatic test_clear_push();
        clear_stat = 1'b1;
        set_in(1'b1, 32'h3C000001, 3'b001);
        step();
        clear_stat = 1'b0;
        set_in(1'b0, 32'h0, 3'b000);
        tests++;
        if (sticky_flags !== 3'b001 || unf_count !== 16'd1 || exc_count !== 16'd0 || ovf_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_with_push: got sticky=%b exc=%0d ovf=%0d unf=%0d, required 001 0 0 1",
                     sticky_flags, exc_count, ovf_count, unf_count);
        end
        drain();
    endtask

    task automatic test_saturation();
        logic [1:0] exp;
        exp = 2'd0;
        tests++;
        if (s_ovf !== exp) begin
            errors++;
            $display("FAIL sat_start: got %0d, required 0", s_ovf);
        end
        sbus.in_valid    = 1'b1;
        sbus.in_overflow = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sbus.in_res = 32'h7F800000 + i;
            step();
            exp = (exp == 2'd3) ? 2'd3 : exp + 2'd1;
            tests++;
            if (s_ovf !== exp) begin
                errors++;
                $display("FAIL sat_count: push %0d got %0d, required %0d", i, s_ovf, exp);
            end
        end
        sbus.in_valid    = 1'b0;
        sbus.in_overflow = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 32'h40490FDB, 3'b111);
        step();
        set_in(1'b1, 32'hBF800000, 3'b101);
        step();
        set_in(1'b0, 32'h0, 3'b000);
        tests++;
        if (level !== 3'd2 || exc_count !== 16'd2) begin
            errors++;
            $display("FAIL mid_pre: got level=%0d exc=%0d, required 2 2", level, exc_count);
        end
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        tests++;
        if (bus.out_valid !== 1'b0 || level !== 3'd0 || sticky_flags !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got ov=%b level=%0d sticky=%b, required 0 0 000",
                     bus.out_valid, level, sticky_flags);
        end
        tests++;
        if (exc_count !== 16'd0 || ovf_count !== 16'd0 || unf_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_counts: got %0d %0d %0d, required 0 0 0", exc_count, ovf_count, unf_count);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        set_in(1'b1, 32'h12345678, 3'b000);
        step();
        set_in(1'b0, 32'h0, 3'b000);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_res !== 32'h12345678 || level !== 3'd1) begin
            errors++;
            $display("FAIL mid_after: got ov=%b res=%h level=%0d, required 1 12345678 1",
                     bus.out_valid, bus.out_res, level);
        end
        drain();
    endtask

    initial begin
        tests        = 0;
        errors       = 0;
        clear_stat   = 1'b0;
        s_clear_stat = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 32'h0, 3'b000);
        sbus.in_valid     = 1'b0;
        sbus.in_res       = 32'h0;
        sbus.in_exception = 1'b0;
        sbus.in_overflow  = 1'b0;
        sbus.in_underflow = 1'b0;
        sbus.out_ready    = 1'b1;

        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_flags();
        test_clear_push();
        test_saturation();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/fp32_mul_result_queue.md
# fp32_mul_result_queue

Buffering stage directly downstream of the combinational FP32 multiplier. It accepts each product word with its exception/overflow/underflow flags over a valid/ready handshake and holds them in a small FIFO so a stalled consumer does not lose results. It also keeps sticky flag status and saturating per-flag event counters for software or bench inspection.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of each event counter
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  multiplier result present
- in_ready  output  1  queue can accept (= not full)
- in_res  input  32  FP32 product word
- in_exception  input  1  multiplier exception flag
- in_overflow  input  1  multiplier overflow flag
- in_underflow  input  1  multiplier underflow flag
- out_valid  output  1  head entry present (= not empty)
- out_ready  input  1  consumer takes head
- out_res  output  32  head FP32 word
- out_flags  output  3  head flags {exception, overflow, underflow}
- level  output  $clog2(DEPTH)+1  current occupancy
- sticky_flags  output  3  OR of flags of all accepted entries since last clear
- clear_stat  input  1  one-cycle pulse: clear sticky_flags and counters
- exc_count, ovf_count, unf_count  output  CNT_W each  accepted entries with that flag set

## Operation
- Push = in_valid & in_ready; pop = out_valid & out_ready. Entry stores {in_res, in_exception, in_overflow, in_underflow} unmodified.
- in_ready depends only on level, never on out_ready (no combinational ready path). Full: in_ready=0, push refused even if pop occurs same cycle.
- Empty: out_valid=0, out_res/out_flags hold last head contents (don't-care); no bypass.
- Simultaneous push and pop when neither full nor empty: level unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally; level tracks full/empty.
- Flags are independent; one entry may raise several (e.g. 1,1,0 for inf×inf) and each matching counter increments.
- Counters saturate at all-ones; no wrap.
- clear_stat with a flagged push in the same cycle: clear applies first, then the new event, so sticky bit = 1 and counter = 1. Set wins.
- Pop does not affect statistics.

## Timing
- Reset (rst_n low, asynchronous): level=0, out_valid=0, sticky_flags=0, all counters 0, out_res=0, out_flags=0, pointers 0. in_ready=1 combinationally, but pushes while rst_n low are ignored.
- Latency: an entry pushed at edge N is visible on out_res/out_valid after edge N, so it is poppable at edge N+1.
- Throughput: one push and one pop per cycle.
- Sticky/counter updates become visible the cycle after the accepting edge.
- Reset mid-operation discards all queued entries immediately, with no partial pop.

## Structure
- Shared package fp32_pkg: FP32_W=32; flag index constants FLAG_EXC=2, FLAG_OVF=1, FLAG_UNF=0; packed typedef fp32_result_t {res[31:0], exc, ovf, unf}.
- Sub-module fp32_sat_counter (parameter W; inputs clk, rst_n, clr, inc; output count). Instantiated three times; clr and inc together yield 1.
- FIFO storage is a flat register array of fp32_result_t inside the top module.

## Test plan
- Push 0x453210E9, flags 000, into an empty queue with out_ready=0 -> next cycle out_valid=1, out_res=0x453210E9, out_flags=000, level=1, sticky=000.
- Push 4 entries (0xC2355062, 0x441E5375, 0x4B800000, 0x361FFFE7) with out_ready=0 -> level=4, in_ready=0, 5th word held. Raise out_ready -> pops in order; 5th accepted the cycle after in_ready returns to 1.
- Steady stream with in_valid=out_ready=1 for 20 cycles -> level stays 1, no loss, output order equals input order.
- Push 0x00000000 with flags 110 (inf×inf) -> sticky=110, exc_count=1, ovf_count=1, unf_count=0.
- clear_stat pulsed in the same cycle as a push with flags 001 -> sticky=001, unf_count=1, other counters 0. With CNT_W=2, five overflow pushes -> ovf_count=3.
- Reset asserted with level=2 and counters nonzero -> out_valid=0, level=0, counters and sticky 0 without waiting for a clock edge; first push after release appears normally.
